// File: rtl/regfile_mp_if.sv
// Bus interface for the multi-port register file.
//
// Handshake semantics: there is no valid/ready pairing on individual ports.
// A write port i is active on a rising clk edge when we[i]=1 and ready=1;
// an issue port j is active when set_en[j]=1 and ready=1. Read ports are
// purely combinational and valid whenever ready=1; they return 0 otherwise.
//
// Signals:
//   we, waddr, wdata        write-back ports (NW of them, packed)
//   set_en, set_addr        issue ports marking a destination busy
//   raddr, rdata, rbusy     read ports (NR of them, packed)
//   ready                   1 once the post-reset clear has finished
//   dbg_addr, dbg_data      raw array peek, no bypass
//   state_dbg               current FSM state (0 = CLEAR, 1 = READY)
// Modports: master drives requests (issue/writeback side), slave is the file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 4,
    parameter int NW     = 2
);
    logic [NW-1:0]        we;
    logic [NW*ADDR_W-1:0] waddr;
    logic [NW*DATA_W-1:0] wdata;
    logic [NW-1:0]        set_en;
    logic [NW*ADDR_W-1:0] set_addr;
    logic [NR*ADDR_W-1:0] raddr;
    logic [NR*DATA_W-1:0] rdata;
    logic [NR-1:0]        rbusy;
    logic                 ready;
    logic [ADDR_W-1:0]    dbg_addr;
    logic [DATA_W-1:0]    dbg_data;
    logic                 state_dbg;

    modport master (
        output we, waddr, wdata, set_en, set_addr, raddr, dbg_addr,
        input  rdata, rbusy, ready, dbg_data, state_dbg
    );

    modport slave (
        input  we, waddr, wdata, set_en, set_addr, raddr, dbg_addr,
        output rdata, rbusy, ready, dbg_data, state_dbg
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// deterministic WAW priority (highest write port wins), a per-register busy
// scoreboard and a sequential hardware clear after reset.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; restarts the clear sequence
//   bus  regfile_mp_if slave modport (write, issue, read and debug ports)
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 4,
    parameter int NW     = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       clr_cnt, clr_cnt_d;
    logic [DATA_W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  ready;

    assign ready         = (state_q == READY);
    assign bus.ready     = ready;
    assign bus.state_dbg = state_q;

    // State and clear-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            clr_cnt <= clr_cnt_d;
        end
    end

    // Next-state logic. The counter walks every address once, then holds.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt + {{ADDR_W{1'b0}}, 1'b1};
                if (clr_cnt == (ADDR_W + 1)'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                clr_cnt_d = clr_cnt;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Array storage. Ports are visited in ascending order so the last
    // non-blocking assignment, from the highest-index port, wins a WAW tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs[clr_cnt[ADDR_W-1:0]] <= '0;
            end else begin
                for (int i = 0; i < NW; i++) begin
                    if (bus.we[i] && (bus.waddr[i*ADDR_W +: ADDR_W] != '0)) begin
                        regs[bus.waddr[i*ADDR_W +: ADDR_W]] <= bus.wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Busy scoreboard: clears from writeback first, then sets from issue, so
    // a newly issued producer keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (state_q == READY) begin
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i]) begin
                    busy[bus.waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            for (int j = 0; j < NW; j++) begin
                if (bus.set_en[j] && (bus.set_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    busy[bus.set_addr[j*ADDR_W +: ADDR_W]] <= 1'b1;
                end
            end
        end
    end

    // Read ports with bypass from same-cycle writes.
    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int r = 0; r < NR; r++) begin
            logic [ADDR_W-1:0] ra;
            logic              hit;
            logic [DATA_W-1:0] byp;
            ra  = bus.raddr[r*ADDR_W +: ADDR_W];
            hit = 1'b0;
            byp = '0;
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i] && (bus.waddr[i*ADDR_W +: ADDR_W] == ra)) begin
                    hit = 1'b1;
                    byp = bus.wdata[i*DATA_W +: DATA_W];
                end
            end
            if (ready && (ra != '0)) begin
                bus.rdata[r*DATA_W +: DATA_W] = hit ? byp : regs[ra];
                bus.rbusy[r]                  = busy[ra] && !hit;
            end
        end
    end

    assign bus.dbg_data = ready ? regs[bus.dbg_addr] : '0;
endmodule
